// File: rtl/dtmf_code_entry.sv
// DTMF keypad code entry: debounces detector frames into key presses, buffers
// a 4-digit code, and reports unlock/fail/timeout with a 3-strike lockout.
module dtmf_code_entry #(
    parameter int unsigned DEBOUNCE_FRAMES = 2,
    parameter int unsigned RELEASE_FRAMES  = 2,
    parameter int unsigned TIMEOUT_FRAMES  = 156,
    parameter int unsigned LOCKOUT_FRAMES  = 1170
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        dtmf_valid,
    input  logic [3:0]  dtmf_data,
    input  logic [15:0] code,
    output logic        key_valid,
    output logic [3:0]  key_data,
    output logic        unlock,
    output logic        fail,
    output logic        timeout,
    output logic        locked,
    output logic [2:0]  digit_count
);

    localparam int unsigned TW = $clog2(TIMEOUT_FRAMES + 1);
    localparam int unsigned LW = $clog2(LOCKOUT_FRAMES + 1);
    localparam logic [3:0]    DEB_N  = 4'(DEBOUNCE_FRAMES);
    localparam logic [3:0]    REL_N  = 4'(RELEASE_FRAMES);
    localparam logic [TW-1:0] TO_N   = TW'(TIMEOUT_FRAMES);
    localparam logic [LW-1:0] LOCK_N = LW'(LOCKOUT_FRAMES);

    typedef enum logic [1:0] {S_SILENT, S_CAND, S_HELD, S_REL} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          key_ev;

    logic [15:0]   buf_q, buf_d;
    logic [2:0]    dcnt_q, dcnt_d;
    logic          ovf_q, ovf_d;
    logic [1:0]    failcnt_q, failcnt_d;
    logic          locked_q, locked_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_data_q, key_data_d;
    logic          unlock_q, unlock_d;
    logic          fail_q, fail_d;
    logic          timeout_q, timeout_d;
    logic          code_ok;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        key_ev  = 1'b0;
        if (frame_tick) begin
            case (state_q)
                S_SILENT: begin
                    if (dtmf_valid) begin
                        state_d = S_CAND;
                        cand_d  = dtmf_data;
                        cnt_d   = 4'd1;
                    end
                end
                S_CAND: begin
                    if (!dtmf_valid) begin
                        state_d = S_SILENT;
                        cnt_d   = '0;
                    end else if (dtmf_data == cand_q) begin
                        if (cnt_q + 4'd1 == DEB_N) begin
                            state_d = S_HELD;
                            cnt_d   = '0;
                            key_ev  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        cand_d = dtmf_data;
                        cnt_d  = 4'd1;
                    end
                end
                S_HELD: begin
                    // A digit change while held is never a new press.
                    if (!dtmf_valid) begin
                        if (REL_N == 4'd1) begin
                            state_d = S_SILENT;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_REL;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                S_REL: begin
                    if (!dtmf_valid) begin
                        if (cnt_q + 4'd1 == REL_N) begin
                            state_d = S_SILENT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (dtmf_data == cand_q) begin
                        state_d = S_HELD;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_CAND;
                        cand_d  = dtmf_data;
                        cnt_d   = 4'd1;
                    end
                end
                default: begin
                    state_d = S_SILENT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign code_ok = (dcnt_q == 3'd4) && !ovf_q && (buf_q == code);

    always_comb begin
        buf_d       = buf_q;
        dcnt_d      = dcnt_q;
        ovf_d       = ovf_q;
        failcnt_d   = failcnt_q;
        locked_d    = locked_q;
        lock_cnt_d  = lock_cnt_q;
        tmr_d       = tmr_q;
        key_data_d  = key_data_q;
        key_valid_d = 1'b0;
        unlock_d    = 1'b0;
        fail_d      = 1'b0;
        timeout_d   = 1'b0;
        if (frame_tick) begin
            if (locked_q) begin
                if (lock_cnt_q <= LW'(1)) begin
                    lock_cnt_d = '0;
                    locked_d   = 1'b0;
                end else begin
                    lock_cnt_d = lock_cnt_q - LW'(1);
                end
            end
            if (key_ev) begin
                key_valid_d = 1'b1;
                key_data_d  = cand_q;
                tmr_d       = '0;
                if (!locked_q) begin
                    case (cand_q)
                        4'd11: begin
                            buf_d  = '0;
                            dcnt_d = '0;
                            ovf_d  = 1'b0;
                        end
                        4'd12: begin
                            buf_d  = '0;
                            dcnt_d = '0;
                            ovf_d  = 1'b0;
                            if (code_ok) begin
                                unlock_d  = 1'b1;
                                failcnt_d = '0;
                            end else begin
                                fail_d = 1'b1;
                                if (failcnt_q == 2'd2) begin
                                    failcnt_d  = '0;
                                    locked_d   = 1'b1;
                                    lock_cnt_d = LOCK_N;
                                end else begin
                                    failcnt_d = failcnt_q + 2'd1;
                                end
                            end
                        end
                        default: begin
                            if (dcnt_q < 3'd4) begin
                                buf_d  = {buf_q[11:0], cand_q};
                                dcnt_d = dcnt_q + 3'd1;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                    endcase
                end
            end else if (dcnt_q != 3'd0 || ovf_q) begin
                if (tmr_q + TW'(1) == TO_N) begin
                    timeout_d = 1'b1;
                    tmr_d     = '0;
                    buf_d     = '0;
                    dcnt_d    = '0;
                    ovf_d     = 1'b0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end else begin
                tmr_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_SILENT;
            cand_q      <= '0;
            cnt_q       <= '0;
            buf_q       <= '0;
            dcnt_q      <= '0;
            ovf_q       <= 1'b0;
            failcnt_q   <= '0;
            locked_q    <= 1'b0;
            lock_cnt_q  <= '0;
            tmr_q       <= '0;
            key_valid_q <= 1'b0;
            key_data_q  <= '0;
            unlock_q    <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            dcnt_q      <= dcnt_d;
            ovf_q       <= ovf_d;
            failcnt_q   <= failcnt_d;
            locked_q    <= locked_d;
            lock_cnt_q  <= lock_cnt_d;
            tmr_q       <= tmr_d;
            key_valid_q <= key_valid_d;
            key_data_q  <= key_data_d;
            unlock_q    <= unlock_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
        end
    end

    assign key_valid   = key_valid_q;
    assign key_data    = key_data_q;
    assign unlock      = unlock_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign locked      = locked_q;
    assign digit_count = dcnt_q;

endmodule

// File: tb/tb_dtmf_code_entry.sv
// Bench for dtmf_code_entry: directed scenarios plus randomized key entry,
// checked frame by frame against a run-length/queue reference model.
module tb_dtmf_code_entry;

    localparam int unsigned DEB   = 2;
    localparam int unsigned RELF  = 2;
    localparam int unsigned TOF   = 20;
    localparam int unsigned LOCKF = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        dtmf_valid = 1'b0;
    logic [3:0]  dtmf_data = '0;
    logic [15:0] code = '0;
    logic        key_valid;
    logic [3:0]  key_data;
    logic        unlock;
    logic        fail;
    logic        timeout;
    logic        locked;
    logic [2:0]  digit_count;

    dtmf_code_entry #(
        .DEBOUNCE_FRAMES(DEB),
        .RELEASE_FRAMES (RELF),
        .TIMEOUT_FRAMES (TOF),
        .LOCKOUT_FRAMES (LOCKF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .dtmf_valid (dtmf_valid),
        .dtmf_data  (dtmf_data),
        .code       (code),
        .key_valid  (key_valid),
        .key_data   (key_data),
        .unlock     (unlock),
        .fail       (fail),
        .timeout    (timeout),
        .locked     (locked),
        .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_kv = 0, n_un = 0, n_fl = 0, n_to = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: key press from run lengths, entry as a digit queue.
    bit m_pressed;
    int m_pdig, m_run_d, m_run_n, m_sil_n;
    int m_q[$];
    bit m_ovf;
    int m_fails, m_lock, m_idle;
    int e_kv, e_kd, e_un, e_fl, e_to;

    task automatic model_reset();
        m_pressed = 0; m_pdig = 0; m_run_d = 0; m_run_n = 0; m_sil_n = 0;
        m_q.delete(); m_ovf = 0; m_fails = 0; m_lock = 0; m_idle = 0;
        e_kv = 0; e_kd = 0; e_un = 0; e_fl = 0; e_to = 0;
    endtask

    function automatic int nib(input logic [15:0] c, input int i);
        logic [15:0] s;
        s = c >> (12 - 4 * i);
        return int'(s[3:0]);
    endfunction

    task automatic model_tick(input bit v, input int d);
        bit kev;
        bit was_locked;
        bit ok;
        kev = 0;
        e_kv = 0; e_un = 0; e_fl = 0; e_to = 0;
        if (v) begin
            if (m_pressed && m_sil_n > 0 && d != m_pdig) m_pressed = 0;
            if (m_run_n > 0 && d == m_run_d) m_run_n++;
            else begin m_run_d = d; m_run_n = 1; end
            m_sil_n = 0;
            if (!m_pressed && m_run_n == DEB) begin
                kev = 1; m_pressed = 1; m_pdig = d;
            end
        end else begin
            m_run_n = 0;
            m_sil_n++;
            if (m_pressed && m_sil_n >= RELF) m_pressed = 0;
        end

        was_locked = (m_lock > 0);
        if (was_locked) m_lock--;
        if (kev) begin
            e_kv = 1; e_kd = d; m_idle = 0;
            if (!was_locked) begin
                if (d == 11) begin
                    m_q.delete(); m_ovf = 0;
                end else if (d == 12) begin
                    ok = (m_q.size() == 4) && !m_ovf;
                    for (int i = 0; i < m_q.size(); i++)
                        if (m_q[i] != nib(code, i)) ok = 0;
                    if (ok) begin
                        e_un = 1; m_fails = 0;
                    end else begin
                        e_fl = 1;
                        if (m_fails == 2) begin m_fails = 0; m_lock = LOCKF; end
                        else m_fails++;
                    end
                    m_q.delete(); m_ovf = 0;
                end else if (m_q.size() < 4) m_q.push_back(d);
                else m_ovf = 1;
            end
        end else if (m_q.size() > 0 || m_ovf) begin
            m_idle++;
            if (m_idle == TOF) begin
                e_to = 1; m_idle = 0; m_q.delete(); m_ovf = 0;
            end
        end else m_idle = 0;
    endtask

    task automatic frame(input bit v, input logic [3:0] d);
        dtmf_valid = v; dtmf_data = d; frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        dtmf_valid = 1'($urandom);
        dtmf_data  = 4'($urandom);
        model_tick(v, int'(d));
        check_eq("key_valid", 32'(key_valid), e_kv);
        check_eq("key_data", 32'(key_data), e_kd);
        check_eq("unlock", 32'(unlock), e_un);
        check_eq("fail", 32'(fail), e_fl);
        check_eq("timeout", 32'(timeout), e_to);
        check_eq("locked", 32'(locked), 32'(m_lock > 0));
        check_eq("digit_count", 32'(digit_count), m_q.size());
        n_kv += int'(key_valid); n_un += int'(unlock);
        n_fl += int'(fail);      n_to += int'(timeout);
        @(posedge clk); #1;
        check_eq("pulse_width", 32'({key_valid, unlock, fail, timeout}), 0);
    endtask

    task automatic press(input logic [3:0] d);
        frame(1'b1, d); frame(1'b1, d); frame(1'b0, 4'd0); frame(1'b0, 4'd0);
    endtask

    task automatic enter4(input logic [15:0] ds);
        for (int i = 0; i < 4; i++) press(4'(nib(ds, i)));
    endtask

    function automatic logic [3:0] rand_digit();
        logic [3:0] d;
        do d = 4'($urandom); while (d == 4'd11 || d == 4'd12);
        return d;
    endfunction

    task automatic rpress(input logic [3:0] d);
        int hold;
        hold = $urandom_range(2, 4);
        for (int i = 0; i < hold; i++) begin
            if ($urandom_range(0, 15) == 0) frame(1'b0, 4'd0);
            else if ($urandom_range(0, 15) == 0) frame(1'b1, 4'($urandom));
            else frame(1'b1, d);
        end
        repeat ($urandom_range(1, 3)) frame(1'b0, 4'd0);
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_reset", 32'({key_valid, key_data, unlock, fail, timeout, locked, digit_count}), 0);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int k;
        model_reset();
        #12;
        check_eq("reset_state", 32'({key_valid, key_data, unlock, fail, timeout, locked, digit_count}), 0);
        @(negedge clk) rst_n = 1'b1;

        // Debounce: accept on 2nd frame, no repeat while held.
        n0 = n_kv;
        frame(1'b1, 4'd5);
        check_eq("r34_no_key_1st", n_kv - n0, 0);
        frame(1'b1, 4'd5);
        check_eq("r34_key_2nd", n_kv - n0, 1);
        check_eq("r34_key_data", 32'(key_data), 5);
        repeat (10) frame(1'b1, 4'd5);
        repeat (2) frame(1'b0, 4'd0);
        check_eq("r34_single", n_kv - n0, 1);
        press(4'd11);

        // Dropout bridging vs real release.
        n0 = n_kv;
        frame(1'b1, 4'd5); frame(1'b1, 4'd5); frame(1'b0, 4'd0);
        frame(1'b1, 4'd5); frame(1'b1, 4'd5);
        repeat (3) frame(1'b0, 4'd0);
        check_eq("r35_dropout", n_kv - n0, 1);
        frame(1'b1, 4'd5); frame(1'b1, 4'd5);
        repeat (3) frame(1'b0, 4'd0);
        check_eq("r35_two_keys", n_kv - n0, 2);
        press(4'd11);

        // Correct and wrong code.
        code = 16'h1A34;
        n0 = n_un;
        enter4(16'h1A34); press(4'd12);
        check_eq("r36_unlock", n_un - n0, 1);
        check_eq("r36_count0", 32'(digit_count), 0);
        n0 = n_fl;
        enter4(16'h1A33); press(4'd12);
        check_eq("r36_fail", n_fl - n0, 1);

        // Overflow, then clear-and-retry.
        n0 = n_fl;
        enter4(16'h1A34); press(4'd7); press(4'd12);
        check_eq("r37_overflow_fail", n_fl - n0, 1);
        n0 = n_un;
        press(4'd2); press(4'd9); press(4'd11);
        enter4(16'h1A34); press(4'd12);
        check_eq("r37_unlock", n_un - n0, 1);

        // Lockout.
        repeat (3) begin enter4(16'h9999); press(4'd12); end
        check_eq("r38_locked", 32'(locked), 1);
        n0 = n_un;
        enter4(16'h1A34); press(4'd12);
        check_eq("r38_inert", n_un - n0, 0);
        k = 0;
        while (locked && k < 200) begin frame(1'b0, 4'd0); k++; end
        check_eq("r38_lock_end", 32'(locked), 0);
        enter4(16'h1A34); press(4'd12);
        check_eq("r38_unlock_after", n_un - n0, 1);

        // Timeout.
        n0 = n_to;
        frame(1'b1, 4'd7); frame(1'b1, 4'd7);
        repeat (TOF + 2) frame(1'b0, 4'd0);
        check_eq("r39_timeout", n_to - n0, 1);
        check_eq("r39_count0", 32'(digit_count), 0);

        // Asynchronous reset mid-entry and mid-lockout.
        press(4'd3); press(4'd4);
        check_eq("mid_entry_count", 32'(digit_count), 2);
        reset_pulse();
        repeat (3) begin press(4'd1); press(4'd12); end
        check_eq("mid_lock_locked", 32'(locked), 1);
        reset_pulse();

        // Randomized entry attempts.
        for (int a = 0; a < 150; a++) begin
            int mode;
            int nd;
            logic [15:0] w;
            if ($urandom_range(0, 7) == 0)
                code = {rand_digit(), rand_digit(), rand_digit(), rand_digit()};
            mode = $urandom_range(0, 5);
            case (mode)
                0: begin
                    for (int i = 0; i < 4; i++) rpress(4'(nib(code, i)));
                    rpress(4'd12);
                end
                1: begin
                    w = code;
                    nd = $urandom_range(0, 3);
                    for (int i = 0; i < 4; i++) begin
                        logic [3:0] dg;
                        dg = 4'(nib(w, i));
                        if (i == nd) begin
                            logic [3:0] r;
                            do r = rand_digit(); while (r == dg);
                            dg = r;
                        end
                        rpress(dg);
                    end
                    rpress(4'd12);
                end
                2: begin
                    nd = $urandom_range(0, 6);
                    for (int i = 0; i < nd; i++) rpress(rand_digit());
                    rpress(4'd12);
                end
                3: begin
                    nd = $urandom_range(1, 3);
                    for (int i = 0; i < nd; i++) rpress(rand_digit());
                    rpress(4'd11);
                    for (int i = 0; i < 4; i++) rpress(4'(nib(code, i)));
                    rpress(4'd12);
                end
                4: begin
                    nd = $urandom_range(1, 3);
                    for (int i = 0; i < nd; i++) rpress(rand_digit());
                    repeat (TOF + 3) frame(1'b0, 4'd0);
                end
                default: begin
                    repeat ($urandom_range(5, 20)) frame(1'($urandom), 4'($urandom));
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
